decode: RTL

DECODE -- requirements
Module: decode

---
 rtl/riscv_structures_pkg.sv | 177 +++++++++++++++++
 rtl/regfile.sv | 32 +++
 rtl/decode.sv | 76 +++++++
 3 files changed

// File: rtl/riscv_structures_pkg.sv
// Shared fetch/decode/execute types, opcode constants and instruction decode helpers.
package riscv_structures;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] instruction_value;
    logic [XLEN-1:0] pc_value;
    logic            pc_r;
    logic            instr_done;
  } fe_to_de_s;

  typedef struct packed {
    logic [XLEN-1:0]   pc_value;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7_5;
    alu_op_e           alu_op;
    logic              alu_src_imm;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
    logic              branch;
    logic              jal;
    logic              jalr;
    logic              lui;
    logic              auipc;
    logic              illegal;
    logic              instr_done;
  } de_to_ex_s;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // Arithmetic op select; only register-register ops honour funct7[5] as SUB.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic f7_5,
                                              input logic is_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_op && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e alu_for_branch(input logic [2:0] f3);
    alu_op_e op;
    case (f3[2:1])
      2'b10:   op = ALU_SLT;
      2'b11:   op = ALU_SLTU;
      default: op = ALU_SUB;
    endcase
    return op;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

  // Static decode of one instruction word; pc, operands and instr_done are filled in by the caller.
  function automatic de_to_ex_s decode_instr(input logic [31:0] ins);
    de_to_ex_s d;
    d          = '0;
    d.rs1      = ins[19:15];
    d.rs2      = ins[24:20];
    d.rd       = ins[11:7];
    d.funct3   = ins[14:12];
    d.funct7_5 = ins[30];
    d.alu_op   = ALU_ADD;
    case (ins[6:0])
      OPC_LUI: begin
        d.imm = imm_u(ins); d.reg_we = 1'b1; d.alu_src_imm = 1'b1; d.lui = 1'b1;
      end
      OPC_AUIPC: begin
        d.imm = imm_u(ins); d.reg_we = 1'b1; d.alu_src_imm = 1'b1; d.auipc = 1'b1;
      end
      OPC_JAL: begin
        d.imm = imm_j(ins); d.reg_we = 1'b1; d.jal = 1'b1;
      end
      OPC_JALR: begin
        d.imm = imm_i(ins); d.reg_we = 1'b1; d.alu_src_imm = 1'b1; d.jalr = 1'b1;
      end
      OPC_BRANCH: begin
        d.imm = imm_b(ins); d.branch = 1'b1; d.alu_op = alu_for_branch(ins[14:12]);
      end
      OPC_LOAD: begin
        d.imm = imm_i(ins); d.reg_we = 1'b1; d.alu_src_imm = 1'b1; d.mem_re = 1'b1;
      end
      OPC_STORE: begin
        d.imm = imm_s(ins); d.alu_src_imm = 1'b1; d.mem_we = 1'b1;
      end
      OPC_OP_IMM: begin
        d.imm = imm_i(ins); d.reg_we = 1'b1; d.alu_src_imm = 1'b1;
        d.alu_op = alu_from_funct3(ins[14:12], ins[30], 1'b0);
      end
      OPC_OP: begin
        d.reg_we = 1'b1;
        d.alu_op = alu_from_funct3(ins[14:12], ins[30], 1'b1);
      end
      OPC_SYSTEM: d.imm = imm_i(ins);
      default:    d.illegal = 1'b1;
    endcase
    if (d.rd == '0) d.reg_we = 1'b0;
    return d;
  endfunction

  // Bubble: fields of the NOP word, no control effect, not a completed instruction.
  function automatic de_to_ex_s make_bubble(input logic [31:0] nop, input logic [XLEN-1:0] pc);
    de_to_ex_s b;
    b             = decode_instr(nop);
    b.pc_value    = pc;
    b.alu_src_imm = 1'b0;
    b.reg_we      = 1'b0;
    b.mem_re      = 1'b0;
    b.mem_we      = 1'b0;
    b.branch      = 1'b0;
    b.jal         = 1'b0;
    b.jalr        = 1'b0;
    b.lui         = 1'b0;
    b.auipc       = 1'b0;
    b.illegal     = 1'b0;
    b.instr_done  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two asynchronous reads, one synchronous write, x0 hardwired to 0.
module regfile
  import riscv_structures::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/decode.sv
// RV32I decode stage: field/immediate decode, operand read with writeback bypass, load-use stall.
module decode
  import riscv_structures::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  fe_to_de_s         fe_to_de,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output de_to_ex_s         de_to_ex
);

  de_to_ex_s         de_to_ex_q, de_to_ex_d;
  de_to_ex_s         dec_c, bubble_c, rst_bubble_c;
  logic [REG_AW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]   rdata1, rdata2;
  logic [6:0]        opc;
  logic              hazard_c;
  logic              unused_pc_r;

  assign opc         = fe_to_de.instruction_value[6:0];
  assign rs1_addr    = fe_to_de.instruction_value[19:15];
  assign rs2_addr    = fe_to_de.instruction_value[24:20];
  assign unused_pc_r = fe_to_de.pc_r;

  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Decode incoming word; a same-cycle writeback to a source wins over the stored value.
  always_comb begin
    dec_c            = decode_instr(fe_to_de.instruction_value);
    dec_c.pc_value   = fe_to_de.pc_value;
    dec_c.instr_done = fe_to_de.instr_done;
    dec_c.rs1_val    = (wb_we && (wb_rd == rs1_addr) && (rs1_addr != '0)) ? wb_data : rdata1;
    dec_c.rs2_val    = (wb_we && (wb_rd == rs2_addr) && (rs2_addr != '0)) ? wb_data : rdata2;
  end

  assign bubble_c     = make_bubble(NOP_INSTR, de_to_ex_q.pc_value);
  assign rst_bubble_c = make_bubble(NOP_INSTR, '0);

  // Load in execute whose destination feeds a source the incoming format actually reads.
  assign hazard_c = de_to_ex_q.instr_done && de_to_ex_q.mem_re && (de_to_ex_q.rd != '0) &&
                    ((uses_rs1(opc) && (de_to_ex_q.rd == rs1_addr)) ||
                     (uses_rs2(opc) && (de_to_ex_q.rd == rs2_addr)));

  assign stall = hazard_c && !flush && !reset;

  always_comb begin
    de_to_ex_d = de_to_ex_q;
    if (flush)     de_to_ex_d = bubble_c;
    else if (en)   de_to_ex_d = stall ? bubble_c : dec_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) de_to_ex_q <= rst_bubble_c;
    else       de_to_ex_q <= de_to_ex_d;
  end

  assign de_to_ex = de_to_ex_q;

endmodule
